// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO interrupt event queue: register map,
// register bit positions and the width of a queued pin index.
package gpio_irq_pkg;

    localparam int IDX_W = 7;

    localparam logic [31:0] ADDR_POP    = 32'h000;
    localparam logic [31:0] ADDR_STATUS = 32'h004;
    localparam logic [31:0] ADDR_CTRL   = 32'h008;

    localparam int POP_VALID_BIT   = 31;
    localparam int ST_COUNT_LSB    = 0;
    localparam int ST_FULL_BIT     = 8;
    localparam int ST_EMPTY_BIT    = 9;
    localparam int ST_COAL_LSB     = 16;
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;

    typedef enum logic [1:0] {
        REG_POP,
        REG_STATUS,
        REG_CTRL,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_reg(input logic [31:0] addr);
        case (addr)
            ADDR_POP:    return REG_POP;
            ADDR_STATUS: return REG_STATUS;
            ADDR_CTRL:   return REG_CTRL;
            default:     return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gpio_irq_fifo.sv
// Event queue of pin indices. Flush beats push/pop; a push is accepted while
// full only if a pop frees a slot in the same cycle. Storage is not reset.
module gpio_irq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_next,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign rdata   = empty ? '0 : mem[rptr];

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (do_push) wptr <= wptr + PW'(1);
                if (do_pop)  rptr <= rptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/apb_gpio_irq_queue.sv
// APB-mapped GPIO interrupt collector: edge-detects pin levels into pending
// bits, queues pin indices lowest-first and raises irq_o while events wait.
module apb_gpio_irq_queue
    import gpio_irq_pkg::*;
#(
    parameter int N_GPIO         = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [N_GPIO-1:0]         interrupt_i,
    output logic                      irq_o
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [N_GPIO-1:0] r_int_d;
    logic [N_GPIO-1:0] pending;
    logic [N_GPIO-1:0] pending_nxt;
    logic [N_GPIO-1:0] rise;
    logic [N_GPIO-1:0] push_mask;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  head;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [7:0]        coalesce;
    logic              enable;
    logic              enable_nxt;
    logic              access, rd, wr;
    logic              push, pop, flush, merge;
    logic              full, empty;
    logic              unused_pwdata;
    reg_sel_e          sel;

    assign PREADY        = 1'b1;
    assign PSLVERR       = 1'b0;
    assign access        = PSEL & PENABLE;
    assign rd            = access & ~PWRITE;
    assign wr            = access & PWRITE;
    assign sel           = decode_reg(32'(PADDR));
    assign flush         = wr & (sel == REG_CTRL) & PWDATA[CTRL_FLUSH_BIT];
    assign pop           = rd & (sel == REG_POP) & ~empty;
    assign rise          = interrupt_i & ~r_int_d & {N_GPIO{enable}};
    assign merge         = |(rise & pending);
    assign enable_nxt    = (wr && sel == REG_CTRL) ? PWDATA[CTRL_ENABLE_BIT] : enable;
    assign unused_pwdata = ^PWDATA[31:2];

    // Lowest-index pending pin wins; a full queue holds it unless a pop frees a slot.
    always_comb begin
        push      = 1'b0;
        push_idx  = '0;
        push_mask = '0;
        for (int i = N_GPIO - 1; i >= 0; i--) begin
            if (pending[i]) begin
                push      = 1'b1;
                push_idx  = IDX_W'(i);
                push_mask = '0;
                push_mask[i] = 1'b1;
            end
        end
        if ((full && !pop) || flush) push = 1'b0;
    end

    // New rises OR in after the clear, so a rise on the pin being pushed keeps it pending.
    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = rise;
        end else begin
            pending_nxt = (pending & ~(push ? push_mask : '0)) | rise;
        end
    end

    gpio_irq_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(IDX_W)
    ) u_fifo (
        .clk       (HCLK),
        .rst       (HRESET),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .wdata     (push_idx),
        .rdata     (head),
        .count     (count),
        .count_next(count_next),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_int_d  <= '0;
            pending  <= '0;
            coalesce <= '0;
            enable   <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            r_int_d <= interrupt_i;
            pending <= pending_nxt;
            enable  <= enable_nxt;
            irq_o   <= enable_nxt & (count_next != '0);
            if (rd && sel == REG_STATUS) begin
                coalesce <= merge ? 8'd1 : 8'd0;
            end else if (merge && coalesce != 8'hFF) begin
                coalesce <= coalesce + 8'd1;
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (sel)
                REG_POP: begin
                    PRDATA[POP_VALID_BIT] = ~empty;
                    PRDATA[IDX_W-1:0]     = head;
                end
                REG_STATUS: begin
                    PRDATA[ST_COUNT_LSB +: 6] = 6'(count);
                    PRDATA[ST_FULL_BIT]       = full;
                    PRDATA[ST_EMPTY_BIT]      = empty;
                    PRDATA[ST_COAL_LSB +: 8]  = coalesce;
                end
                REG_CTRL: PRDATA[CTRL_ENABLE_BIT] = enable;
                default:  PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_gpio_irq_queue.sv
// Directed bench for apb_gpio_irq_queue: latency, ordering, overflow hold,
// coalescing, flush and asynchronous reset, with hand-computed expectations.
module tb_apb_gpio_irq_queue;
    localparam int N_GPIO     = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int AW         = 12;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [AW-1:0]     PADDR;
    logic [31:0]       PWDATA;
    logic              PWRITE, PSEL, PENABLE;
    logic [31:0]       PRDATA;
    logic              PREADY, PSLVERR;
    logic [N_GPIO-1:0] interrupt_i;
    logic              irq_o;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] rdata;
    int          order [3] = '{1, 3, 7};

    apb_gpio_irq_queue #(
        .N_GPIO(N_GPIO),
        .FIFO_DEPTH(FIFO_DEPTH),
        .APB_ADDR_WIDTH(AW)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .interrupt_i(interrupt_i), .irq_o(irq_o)
    );

    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    // Starts and ends on a falling edge; data is sampled in the access phase.
    task automatic apb_read(input logic [AW-1:0] addr, output logic [31:0] data);
        PADDR = addr; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1 data = PRDATA;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [AW-1:0] addr, input logic [31:0] data);
        PADDR = addr; PWDATA = data; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(addr, d);
        checkOutput(tag, d, exp);
    endtask

    initial begin
        HRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        interrupt_i = '0;
        #1 checkOutput("reset_irq", {31'b0, irq_o}, 32'd0);
        wait_cycles(2);
        HRESET = 1'b0;
        checkOutput("pready", {31'b0, PREADY}, 32'd1);
        checkOutput("pslverr", {31'b0, PSLVERR}, 32'd0);
        read_check("reset_ctrl", 12'h008, 32'h0);
        read_check("reset_status", 12'h004, 32'h0000_0200);
        read_check("reset_pop", 12'h000, 32'h0);
        read_check("unmapped", 12'h00C, 32'h0);

        apb_write(12'h008, 32'h1);
        read_check("ctrl_en", 12'h008, 32'h1);

        // Single rise on pin 5: irq two edges later, then drained by a POP.
        interrupt_i[5] = 1'b1;
        @(posedge HCLK); #1 checkOutput("lat_edge1_irq", {31'b0, irq_o}, 32'd0);
        @(posedge HCLK); #1 checkOutput("lat_edge2_irq", {31'b0, irq_o}, 32'd1);
        @(negedge HCLK);
        read_check("pop_pin5", 12'h000, 32'h8000_0005);
        read_check("pop_empty1", 12'h000, 32'h0);
        checkOutput("irq_drop1", {31'b0, irq_o}, 32'd0);
        interrupt_i = '0;
        wait_cycles(2);

        // Simultaneous rises drain lowest index first.
        interrupt_i = 32'h0000_008A;
        wait_cycles(6);
        for (int k = 0; k < 3; k++) begin
            apb_read(12'h000, rdata);
            checkOutput($sformatf("order_%0d", k), rdata, 32'h8000_0000 | 32'(order[k]));
        end
        read_check("order_empty", 12'h000, 32'h0);
        interrupt_i = '0;
        wait_cycles(2);

        // Ten rises into an eight-deep queue: the last two wait in pending.
        interrupt_i = 32'h0000_03FF;
        wait_cycles(14);
        read_check("ovf_status", 12'h004, 32'h0000_0108);
        read_check("ovf_pop0", 12'h000, 32'h8000_0000);
        read_check("ovf_pop1", 12'h000, 32'h8000_0001);
        wait_cycles(3);
        read_check("ovf_refill", 12'h004, 32'h0000_0108);
        for (int k = 2; k < 10; k++) begin
            apb_read(12'h000, rdata);
            checkOutput($sformatf("ovf_pop%0d", k), rdata, 32'h8000_0000 | 32'(k));
        end
        read_check("ovf_drained", 12'h004, 32'h0000_0200);
        interrupt_i = '0;
        wait_cycles(2);

        // Fill the queue without pin 2, then toggle pin 2 three times.
        interrupt_i = 32'h0000_02FB;
        wait_cycles(12);
        read_check("coal_full", 12'h004, 32'h0000_0108);
        repeat (3) begin
            interrupt_i[2] = 1'b1;
            @(negedge HCLK);
            interrupt_i[2] = 1'b0;
            @(negedge HCLK);
        end
        read_check("coal_two", 12'h004, 32'h0002_0108);
        read_check("coal_clear", 12'h004, 32'h0000_0108);
        apb_write(12'h008, 32'h3);
        interrupt_i = '0;
        wait_cycles(2);
        read_check("flush_all", 12'h004, 32'h0000_0200);
        read_check("flush_bit_ro", 12'h008, 32'h1);

        // Flush with four queued and pin 20 pending; pin 21 rises in the flush cycle.
        interrupt_i = 32'h0000_3C00;
        wait_cycles(8);
        read_check("pre_flush", 12'h004, 32'h0000_0004);
        checkOutput("pre_flush_irq", {31'b0, irq_o}, 32'd1);
        PADDR = 12'h008; PWDATA = 32'h3; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        interrupt_i[20] = 1'b1;
        @(negedge HCLK);
        PENABLE = 1'b1;
        interrupt_i[21] = 1'b1;
        @(posedge HCLK); #1 checkOutput("flush_irq", {31'b0, irq_o}, 32'd0);
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        read_check("post_flush", 12'h004, 32'h0000_0001);
        read_check("post_flush_pop", 12'h000, 32'h8000_0015);
        read_check("post_flush_empty", 12'h000, 32'h0);
        checkOutput("post_flush_irq", {31'b0, irq_o}, 32'd0);
        interrupt_i = '0;
        wait_cycles(2);

        // Reset in the middle of a STATUS access with three events queued.
        interrupt_i = 32'h0000_0007;
        wait_cycles(6);
        checkOutput("pre_rst_irq", {31'b0, irq_o}, 32'd1);
        PADDR = 12'h004; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1 checkOutput("pre_rst_status", PRDATA, 32'h0000_0003);
        HRESET = 1'b1;
        #1 checkOutput("async_rst_irq", {31'b0, irq_o}, 32'd0);
        checkOutput("async_rst_status", PRDATA, 32'h0000_0200);
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        HRESET = 1'b0;
        wait_cycles(2);
        read_check("post_rst_status", 12'h004, 32'h0000_0200);
        read_check("post_rst_ctrl", 12'h008, 32'h0);
        checkOutput("post_rst_irq", {31'b0, irq_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_gpio_irq_queue.md
APB_GPIO_IRQ_QUEUE -- requirements
Module: apb_gpio_irq_queue

Interface
REQ-001 SHALL have parameter N_GPIO, default 32, meaning the number of per-pin interrupt inputs (2..128).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of event-queue entries (power of 2, 2..32).
REQ-003 SHALL have parameter APB_ADDR_WIDTH, default 12, meaning the APB address width.
REQ-004 SHALL have port HCLK  in  1  the single clock; all state is on its rising edge.
REQ-005 SHALL have port HRESET  in  1  reset: asynchronous, active-high.
REQ-006 SHALL have ports PADDR in APB_ADDR_WIDTH, PWDATA in 32, PWRITE in 1, PSEL in 1, PENABLE in 1: APB slave request.
REQ-007 SHALL have ports PRDATA out 32, PREADY out 1, PSLVERR out 1: APB slave response.
REQ-008 SHALL have port interrupt_i  in  N_GPIO  per-pin interrupt levels from the GPIO controller.
REQ-009 SHALL have port irq_o  out  1  request to the core event unit.

Function
REQ-010 SHALL tie PREADY to 1 and PSLVERR to 0; an access occurs when PSEL & PENABLE are both high.
REQ-011 SHALL register interrupt_i every cycle (r_int_d) and detect a rise as interrupt_i & ~r_int_d.
REQ-012 SHALL set pending[i] one cycle after a rise on pin i when CTRL.enable=1; rises while enable=0 are ignored.
REQ-013 SHALL merge a rise on pin i that arrives while pending[i] is already 1, and SHALL increment an 8-bit coalesce counter that saturates at 255.
REQ-014 SHALL select, each cycle when the FIFO is not full, the lowest-index set pending bit, push its index (7 bits) into the FIFO, and clear that bit.
REQ-015 SHALL keep a pending bit set when the FIFO is full (no loss); it is pushed in the first cycle a slot frees.
REQ-016 SHALL give set priority when a new rise on pin i coincides with pin i being pushed: pending[i] stays 1.
REQ-017 SHALL give a latency from the interrupt_i rise (sampled at edge n) to pending at n+1, FIFO entry at n+2, and irq_o=1 at n+2.
REQ-018 SHALL drive irq_o registered as CTRL.enable & (FIFO count != 0).
REQ-019 SHALL implement register 0x000 POP (RO): PRDATA[31]=~empty, PRDATA[6:0]=head index (0 when empty); a read pops the FIFO when it is non-empty; a read when empty has no effect.
REQ-020 SHALL implement register 0x004 STATUS (RO): [5:0]=count, [8]=full, [9]=empty, [23:16]=coalesce counter; a read clears the coalesce counter, and a simultaneous increment then yields 1.
REQ-021 SHALL implement register 0x008 CTRL (RW): [0]=enable, reset 0; writing [1]=1 flushes the FIFO and all pending bits in the same cycle, and bit 1 reads 0.
REQ-022 SHALL read unmapped addresses as 0 and ignore writes to them and to RO registers.
REQ-023 SHALL make PRDATA combinational from the current state during the access cycle.
REQ-024 SHALL let a push and a pop in the same cycle both occur, leaving count unchanged; a pop when full and a push in the same cycle are legal.
REQ-025 SHALL make flush win over a simultaneous push or pop; a rise in the flush cycle is still captured into pending on the next edge.
REQ-026 SHALL wrap the read and write pointers modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Reset
REQ-027 SHALL, while HRESET=1, asynchronously clear r_int_d, pending, the FIFO pointers and count, the coalesce counter, CTRL.enable, and irq_o.
REQ-028 SHALL not reset FIFO storage; POP returns 0 data when empty regardless.
REQ-029 SHALL ignore rises present on the first edge after reset release if r_int_d has not yet been loaded (r_int_d reset to 0 means a high level counts as a rise).

Structure
REQ-030 SHALL place the register offsets (0x000/0x004/0x008), STATUS/CTRL bit positions, and the index width constant (7) in the shared package gpio_irq_pkg.
REQ-031 SHALL implement the FIFO as a separate sub-module gpio_irq_fifo (push/pop/flush, data, count, full, empty).

Verification
REQ-032 SHALL cover: enable=1, rise on pin 5 -> irq_o=1 two edges later; POP read returns 0x8000_0005; the next POP returns 0; irq_o drops.
REQ-033 SHALL cover: simultaneous rises on pins 3, 1, 7 -> POP sequence 1, 3, 7, then empty.
REQ-034 SHALL cover: FIFO_DEPTH=8, rises on pins 0..9 -> STATUS count=8, full=1; two POPs -> pins 8 and 9 enqueue with none lost.
REQ-035 SHALL cover: pin 2 toggling 3 times while pending is held (FIFO full) -> coalesce=2; a STATUS read returns 2, then reads 0.
REQ-036 SHALL cover: flush write with count=4 and pending set -> count=0, irq_o=0 the next cycle; a rise in the same cycle is queued afterwards.
REQ-037 SHALL cover: HRESET asserted mid-queue -> irq_o=0 and STATUS=0x0000_0200 immediately, without a clock edge.
